aluctrl_md: RTL and testbench

Parametrised successor to the single-cycle ALU control decoder. It decodes AluOp and funct into a 4-bit ALU control code, extending the funct set to and, or, xor, nor and slt. It also adds an iterative multiply/divide sequencer that owns the HI/LO registers and stalls the pipeline while busy. It sits beside the main ALU in the EX stage of mipsCPU; the pipeline holds EX while stall is high.

---
 rtl/aluctrl_pkg.sv | 48 ++++
 rtl/md_iter.sv | 98 +++++++++
 rtl/aluctrl_md.sv | 176 +++++++++++++++++
 tb/tb_aluctrl_md.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aluctrl_pkg.sv
// Shared encodings for the ALU control decoder and the multiply/divide sequencer.
package aluctrl_pkg;

    // ALU control codes driven to the main EX-stage ALU
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // R-type function field values
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    // AluOp encodings from the main decoder
    typedef enum logic [1:0] {
        AOP_ADD   = 2'b00,
        AOP_SUB   = 2'b01,
        AOP_OR    = 2'b10,
        AOP_RTYPE = 2'b11
    } aluop_e;

    // Multiply/divide sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } md_state_e;

    // True for the four HI/LO-writing funct codes (0110xx)
    function automatic logic is_md_funct(input logic [5:0] f);
        return (f[5:2] == 4'b0110);
    endfunction

endpackage

// File: rtl/md_iter.sv
// Iterative datapath: radix-2 shift-add multiply and restoring divide on
// unsigned magnitudes. {acc,quo} holds {hi,lo} of the raw result.
module md_iter
    import aluctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             last,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] opd_q, opd_d;
    logic             div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   shl_s;
    logic [WIDTH-1:0] diff_s;
    logic             ge_s;

    // One iteration step: load operands, or advance multiply/divide by one bit
    always_comb begin
        acc_d  = acc_q;
        quo_d  = quo_q;
        opd_d  = opd_q;
        div_d  = div_q;
        cnt_d  = cnt_q;
        sum_s  = {1'b0, acc_q} + {1'b0, opd_q};
        shl_s  = {acc_q, quo_q[WIDTH-1]};
        ge_s   = (shl_s >= {1'b0, opd_q});
        // remainder stays below the divisor, so the low WIDTH bits suffice
        diff_s = shl_s[WIDTH-1:0] - opd_q;
        if (load) begin
            acc_d = {WIDTH{1'b0}};
            quo_d = op_a;
            opd_d = op_b;
            div_d = is_div;
            cnt_d = CNT_W'(WIDTH);
        end else if (step) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (div_q) begin
                if (ge_s) begin
                    acc_d = diff_s;
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = shl_s[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                if (quo_q[0]) begin
                    acc_d = sum_s[WIDTH:1];
                    quo_d = {sum_s[0], quo_q[WIDTH-1:1]};
                end else begin
                    acc_d = {1'b0, acc_q[WIDTH-1:1]};
                    quo_d = {acc_q[0], quo_q[WIDTH-1:1]};
                end
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Datapath and iteration counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= {WIDTH{1'b0}};
            quo_q <= {WIDTH{1'b0}};
            opd_q <= {WIDTH{1'b0}};
            div_q <= 1'b0;
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            acc_q <= acc_d;
            quo_q <= quo_d;
            opd_q <= opd_d;
            div_q <= div_d;
            cnt_q <= cnt_d;
        end
    end

    // Final-step flag and raw result view
    always_comb begin
        last   = step && (cnt_q == CNT_W'(1));
        res_hi = acc_q;
        res_lo = quo_q;
    end

endmodule

// File: rtl/aluctrl_md.sv
// ALU control decoder plus multiply/divide sequencer owning HI/LO.
// Holds the EX stage (stall) while an MD op or HI/LO read meets a busy unit.
module aluctrl_md
    import aluctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic             issue,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [3:0]       aluctrl,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    md_state_e        state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] araw_q, araw_d;
    logic             div_q, div_d;
    logic             neg_q, neg_d;
    logic             rneg_q, rneg_d;
    logic             dz_q, dz_d;

    logic             rtype_s, md_op_s, rd_hilo_s, load_s, run_s, last_s;
    logic             sgn_s, a_neg_s, b_neg_s;
    logic [WIDTH-1:0] abs_a_s, abs_b_s, res_hi_s, res_lo_s;
    logic [2*WIDTH-1:0] prod_s;

    // Instruction classification and operand magnitudes
    always_comb begin
        rtype_s   = (alu_op == AOP_RTYPE);
        md_op_s   = rtype_s && is_md_funct(funct);
        rd_hilo_s = rtype_s && ((funct == FN_MFHI) || (funct == FN_MFLO));
        sgn_s     = ~funct[0];
        a_neg_s   = sgn_s && src_a[WIDTH-1];
        b_neg_s   = sgn_s && src_b[WIDTH-1];
        // most-negative maps onto itself, which is the right unsigned magnitude
        abs_a_s   = a_neg_s ? -src_a : src_a;
        abs_b_s   = b_neg_s ? -src_b : src_b;
        load_s    = (state_q == ST_IDLE) && issue && md_op_s;
        run_s     = (state_q == ST_RUN);
    end

    // ALU control decode, independent of the sequencer
    always_comb begin
        aluctrl = ALU_OR;
        case (alu_op)
            AOP_ADD: aluctrl = ALU_ADD;
            AOP_SUB: aluctrl = ALU_SUB;
            AOP_OR:  aluctrl = ALU_OR;
            AOP_RTYPE: begin
                case (funct)
                    FN_ADDU: aluctrl = ALU_ADD;
                    FN_SUBU: aluctrl = ALU_SUB;
                    FN_AND:  aluctrl = ALU_AND;
                    FN_OR:   aluctrl = ALU_OR;
                    FN_XOR:  aluctrl = ALU_XOR;
                    FN_NOR:  aluctrl = ALU_NOR;
                    FN_SLT:  aluctrl = ALU_SLT;
                    default: aluctrl = ALU_OR;
                endcase
            end
            default: aluctrl = ALU_OR;
        endcase
    end

    md_iter #(.WIDTH(WIDTH)) u_md_iter (
        .clk    (clk),
        .rst    (rst),
        .load   (load_s),
        .step   (run_s),
        .is_div (funct[1]),
        .op_a   (abs_a_s),
        .op_b   (abs_b_s),
        .last   (last_s),
        .res_hi (res_hi_s),
        .res_lo (res_lo_s)
    );

    // Next-state logic of the sequencer
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = load_s ? ST_RUN : ST_IDLE;
            ST_RUN:  state_d = last_s ? ST_DONE : ST_RUN;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture the sign fixup and divide-by-zero info at issue
    always_comb begin
        div_d  = div_q;
        neg_d  = neg_q;
        rneg_d = rneg_q;
        dz_d   = dz_q;
        araw_d = araw_q;
        if (load_s) begin
            div_d  = funct[1];
            neg_d  = a_neg_s ^ b_neg_s;
            rneg_d = a_neg_s;
            dz_d   = funct[1] && (src_b == {WIDTH{1'b0}});
            araw_d = src_a;
        end else begin
            div_d  = div_q;
        end
    end

    // State register and issue-time control flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            araw_q  <= {WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            araw_q  <= araw_d;
        end
    end

    // Sign fixup in DONE; HI/LO change only then
    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        prod_s = {res_hi_s, res_lo_s};
        if (state_q == ST_DONE) begin
            if (div_q) begin
                if (dz_q) begin
                    hi_d = araw_q;
                    lo_d = {WIDTH{1'b1}};
                end else begin
                    hi_d = rneg_q ? -res_hi_s : res_hi_s;
                    lo_d = neg_q ? -res_lo_s : res_lo_s;
                end
            end else begin
                {hi_d, lo_d} = neg_q ? -prod_s : prod_s;
            end
        end else begin
            hi_d = hi_q;
        end
    end

    // HI/LO registers
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= {WIDTH{1'b0}};
            lo_q <= {WIDTH{1'b0}};
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    // Sequencer status outputs and hazard stall
    always_comb begin
        busy  = (state_q != ST_IDLE);
        done  = (state_q == ST_DONE);
        stall = issue && (md_op_s || rd_hilo_s) && (state_q != ST_IDLE);
        hi    = hi_q;
        lo    = lo_q;
    end

endmodule

// File: tb/tb_aluctrl_md.sv
// Self-checking bench for aluctrl_md: cycle-level reference model plus
// hand-computed anchors from the behavioural description.
module tb_aluctrl_md;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   alu_op;
    logic [5:0]   funct;
    logic         issue;
    logic [W-1:0] src_a, src_b;
    logic [3:0]   aluctrl;
    logic         stall, busy, done;
    logic [W-1:0] hi, lo;

    int checks = 0;
    int errors = 0;

    // reference model state: mk = cycles since accepted issue (0 = idle)
    int           mk = 0;
    logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    bit           chk_en = 1'b0;
    int           done_seen = 0;

    logic [5:0] fn_tab [13] = '{6'b100001, 6'b100011, 6'b100100, 6'b100101,
                                6'b100110, 6'b100111, 6'b101010, 6'b011000,
                                6'b011001, 6'b011010, 6'b011011, 6'b010000,
                                6'b010010};

    aluctrl_md #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .alu_op(alu_op), .funct(funct), .issue(issue),
        .src_a(src_a), .src_b(src_b), .aluctrl(aluctrl), .stall(stall),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] ref_ctrl(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'b00) return 4'b0010;
        if (op == 2'b01) return 4'b0110;
        if (op == 2'b10) return 4'b0001;
        case (f)
            6'b100001: return 4'b0010;
            6'b100011: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b100110: return 4'b0011;
            6'b100111: return 4'b1100;
            6'b101010: return 4'b0111;
            default:   return 4'b0001;
        endcase
    endfunction

    function automatic bit ref_md(input logic [5:0] f);
        return (f == 6'b011000) || (f == 6'b011001) || (f == 6'b011010) || (f == 6'b011011);
    endfunction

    // {hi,lo} from plain integer arithmetic
    function automatic logic [63:0] ref_result(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, q, r;
        logic [63:0] u;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        u = 64'd0;
        case (f)
            6'b011000: u = sa * sb;
            6'b011001: u = {32'd0, a} * {32'd0, b};
            6'b011010: begin
                if (b == 32'd0) u = {a, 32'hFFFFFFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    u = {r[31:0], q[31:0]};
                end
            end
            6'b011011: begin
                if (b == 32'd0) u = {a, 32'hFFFFFFFF};
                else u = {a % b, a / b};
            end
            default: u = 64'd0;
        endcase
        return u;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model advanced on each active edge
    always @(posedge clk) begin
        if (rst) begin
            mk   <= 0;
            m_hi <= '0;
            m_lo <= '0;
        end else if (mk == 0) begin
            if (issue && alu_op == 2'b11 && ref_md(funct)) begin
                mk <= 1;
                {p_hi, p_lo} <= ref_result(funct, src_a, src_b);
            end
        end else if (mk <= W) begin
            mk <= mk + 1;
        end else begin
            mk   <= 0;
            m_hi <= p_hi;
            m_lo <= p_lo;
        end
    end

    // per-cycle comparison on the inactive edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("aluctrl", 64'(aluctrl), 64'(ref_ctrl(alu_op, funct)));
            check("busy", 64'(busy), 64'(mk != 0));
            check("done", 64'(done), 64'(mk == W + 1));
            check("stall", 64'(stall), 64'(issue && alu_op == 2'b11 &&
                  (ref_md(funct) || funct == 6'b010000 || funct == 6'b010010) && mk != 0));
            check("hi", 64'(hi), 64'(m_hi));
            check("lo", 64'(lo), 64'(m_lo));
            if (done) done_seen++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setin(input logic i, input logic [1:0] op, input logic [5:0] f,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        issue  = i;
        alu_op = op;
        funct  = f;
        src_a  = a;
        src_b  = b;
    endtask

    task automatic run_md(input string name, input logic [5:0] f, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo);
        setin(1'b1, 2'b11, f, a, b);
        tick();
        setin(1'b0, 2'b00, 6'd0, '0, '0);
        repeat (W + 1) tick();
        check({name, "_hi"}, 64'(hi), 64'(ehi));
        check({name, "_lo"}, 64'(lo), 64'(elo));
    endtask

    function automatic logic [W-1:0] pick_op();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFFFFFF;
            3:       return 32'h80000000;
            4:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    logic [1:0] dop [8] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11};
    logic [5:0] dfn [8] = '{6'b000000, 6'b000000, 6'b000000, 6'b100100,
                            6'b100110, 6'b100111, 6'b101010, 6'b111111};
    logic [3:0] dex [8] = '{4'b0010, 4'b0110, 4'b0001, 4'b0000,
                            4'b0011, 4'b1100, 4'b0111, 4'b0001};

    initial begin
        setin(1'b0, 2'b00, 6'd0, '0, '0);
        rst = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);

        // decode sweep
        for (int i = 0; i < 8; i++) begin
            setin(1'b0, dop[i], dfn[i], '0, '0);
            #2;
            check("decode", 64'(aluctrl), 64'(dex[i]));
            tick();
        end

        // signed multiply with single done pulse
        done_seen = 0;
        run_md("mult", 6'b011000, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
        check("mult_done_cnt", 64'(done_seen), 64'd1);
        run_md("divu", 6'b011011, 32'd100, 32'd7, 32'h00000002, 32'h0000000E);
        run_md("div_neg", 6'b011010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_md("div_zero", 6'b011010, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF);
        run_md("div_ovf", 6'b011010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

        // hazards during a running multiply
        setin(1'b1, 2'b11, 6'b011000, 32'd5, 32'd6);
        tick();
        setin(1'b0, 2'b00, 6'd0, '0, '0);
        repeat (3) tick();
        setin(1'b1, 2'b11, 6'b100001, 32'd1, 32'd1);
        #2;
        check("addu_nostall", 64'(stall), 64'd0);
        check("addu_ctrl", 64'(aluctrl), 64'b0010);
        tick();
        setin(1'b1, 2'b11, 6'b010010, '0, '0);
        #2;
        check("mflo_stall", 64'(stall), 64'd1);
        tick();
        setin(1'b1, 2'b11, 6'b011000, 32'd9, 32'd9);
        #2;
        check("mult2_stall", 64'(stall), 64'd1);
        tick();
        setin(1'b1, 2'b11, 6'b010010, '0, '0);
        repeat (27) tick();
        check("mflo_release", 64'(stall), 64'd0);
        check("haz_lo", 64'(lo), 64'd30);
        check("haz_hi", 64'(hi), 64'd0);
        setin(1'b0, 2'b00, 6'd0, '0, '0);
        tick();

        // reset in the middle of RUN
        setin(1'b1, 2'b11, 6'b011000, 32'd7, 32'd7);
        tick();
        done_seen = 0;
        setin(1'b0, 2'b00, 6'd0, '0, '0);
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        repeat (30) tick();
        check("abort_nodone", 64'(done_seen), 64'd0);
        run_md("multu", 6'b011001, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) != 0)
                setin(1'($urandom_range(0, 1)), 2'($urandom), fn_tab[$urandom_range(0, 12)], pick_op(), pick_op());
            else
                setin(1'($urandom_range(0, 1)), 2'($urandom), 6'($urandom), pick_op(), pick_op());
            tick();
        end
        rst = 1'b0;
        setin(1'b0, 2'b00, 6'd0, '0, '0);
        repeat (W + 3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
